spike_fire_unit: RTL and testbench

Fire-decision and spike-emission stage that sits directly downstream of the neuron configuration memory's read port B. It accepts integrated membrane potentials from the accumulation stage and issues the matching read on config port B. It applies the per-neuron threshold rule (fixed or LFSR-randomised, I&F or ReLU) and writes the updated potential back. Fired neurons' AER words are queued in a small FIFO that drains to the router over a valid/ready handshake.

---
 rtl/spike_fire_unit.sv | 164 ++++++++++++++++
 tb/tb_spike_fire_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_fire_unit.sv
// spike_fire_unit
// Fire-decision and spike-emission stage. Accepts integrated potentials, reads
// the neuron's config on port B, applies the threshold rule, writes the updated
// potential back and queues AER words of fired neurons toward the router.
module spike_fire_unit #(
    parameter int          NUM_NURNS          = 256,
    parameter int          NURN_CNT_BIT_WIDTH = 8,
    parameter int          DSIZE              = 16,
    parameter int          AER_BIT_WIDTH      = 32,
    parameter int          FIFO_DEPTH         = 8,
    parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              pot_valid_i,
    output logic                              pot_ready_o,
    input  logic [NURN_CNT_BIT_WIDTH-1:0]     pot_nurn_i,
    input  logic [DSIZE-1:0]                  pot_i,
    output logic [NURN_CNT_BIT_WIDTH-1:0]     Addr_Config_B_o,
    output logic                              rdEn_Config_B_o,
    input  logic                              NurnType_i,
    input  logic                              RandTh_i,
    input  logic [DSIZE-1:0]                  Th_Mask_i,
    input  logic [DSIZE-1:0]                  RstPot_i,
    input  logic [AER_BIT_WIDTH-1:0]          SpikeAER_i,
    output logic                              wb_valid_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]     wb_nurn_o,
    output logic [DSIZE-1:0]                  wb_pot_o,
    output logic                              spike_valid_o,
    input  logic                              spike_ready_i,
    output logic [AER_BIT_WIDTH-1:0]          spike_aer_o,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Stage-1 pipeline registers
    logic                          s1_valid;
    logic [NURN_CNT_BIT_WIDTH-1:0] s1_nurn;
    logic [DSIZE-1:0]              s1_pot;

    // Threshold randomiser
    logic [15:0]      lfsr;
    logic [DSIZE-1:0] lfsr_ext;

    // Spike FIFO storage and pointers (extra MSB is the wrap bit)
    logic [AER_BIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]           wr_ptr;
    logic [PTR_W:0]           rd_ptr;
    logic [CNT_W-1:0]         count;

    logic             nurn_ok;
    logic             acc;
    logic [DSIZE-1:0] th;
    logic             over_th;
    logic             fire;
    logic [DSIZE-1:0] next_pot;
    logic             push;
    logic             pop;

    // Indices beyond the core's neuron count are consumed but never processed
    assign nurn_ok = ({1'b0, pot_nurn_i} < (NURN_CNT_BIT_WIDTH + 1)'(NUM_NURNS));

    // Stall intake whenever the in-flight neuron could find the FIFO full
    assign pot_ready_o = ({1'b0, count} + {{CNT_W{1'b0}}, s1_valid}) < (CNT_W + 1)'(FIFO_DEPTH);

    assign acc             = pot_valid_i & pot_ready_o & nurn_ok;
    assign Addr_Config_B_o = pot_nurn_i;
    assign rdEn_Config_B_o = acc;

    // LFSR is zero-extended or truncated to the potential width
    generate
        if (DSIZE > 16) begin : g_lfsr_wide
            assign lfsr_ext = {{(DSIZE - 16){1'b0}}, lfsr};
        end else begin : g_lfsr_narrow
            assign lfsr_ext = lfsr[DSIZE-1:0];
        end
    endgenerate

    assign th      = RandTh_i ? (lfsr_ext & Th_Mask_i) : Th_Mask_i;
    assign over_th = ($signed(s1_pot) >= $signed(th));

    // Threshold rule: I&F fires and resets, ReLU never fires and clamps negatives
    always_comb begin
        fire     = 1'b0;
        next_pot = s1_pot;
        if (NurnType_i) begin
            next_pot = s1_pot[DSIZE-1] ? '0 : s1_pot;
        end else if (over_th) begin
            fire     = s1_valid;
            next_pot = RstPot_i;
        end
    end

    assign count         = wr_ptr - rd_ptr;
    assign fifo_cnt_o    = count;
    assign spike_valid_o = (count != '0);
    assign spike_aer_o   = mem[rd_ptr[PTR_W-1:0]];
    assign pop           = spike_valid_o & spike_ready_i;
    assign push          = fire & ((count < CNT_W'(FIFO_DEPTH)) | pop);

    // Capture the accepted potential while the config read is in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_nurn  <= '0;
            s1_pot   <= '0;
        end else begin
            s1_valid <= acc;
            if (acc) begin
                s1_nurn <= pot_nurn_i;
                s1_pot  <= pot_i;
            end
        end
    end

    // Register the potential writeback, one pulse per evaluated neuron
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_valid_o <= 1'b0;
            wb_nurn_o  <= '0;
            wb_pot_o   <= '0;
        end else begin
            wb_valid_o <= s1_valid;
            if (s1_valid) begin
                wb_nurn_o <= s1_nurn;
                wb_pot_o  <= next_pot;
            end
        end
    end

    // Galois LFSR steps only when a randomised-threshold neuron is evaluated
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr <= LFSR_SEED;
        end else if (s1_valid && RandTh_i) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // FIFO pointers; simultaneous push and pop advance both
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage is not reset; contents are only visible behind valid
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= SpikeAER_i;
        end
    end

endmodule

// File: tb/tb_spike_fire_unit.sv
// tb_spike_fire_unit
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a cycle-level behavioural model of the fire rule and spike queue.
module tb_spike_fire_unit;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        pot_valid_i;
    logic        pot_ready_o;
    logic [7:0]  pot_nurn_i;
    logic [15:0] pot_i;
    logic [7:0]  Addr_Config_B_o;
    logic        rdEn_Config_B_o;
    logic        NurnType_i;
    logic        RandTh_i;
    logic [15:0] Th_Mask_i;
    logic [15:0] RstPot_i;
    logic [31:0] SpikeAER_i;
    logic        wb_valid_o;
    logic [7:0]  wb_nurn_o;
    logic [15:0] wb_pot_o;
    logic        spike_valid_o;
    logic        spike_ready_i;
    logic [31:0] spike_aer_o;
    logic [3:0]  fifo_cnt_o;

    spike_fire_unit dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .pot_valid_i(pot_valid_i), .pot_ready_o(pot_ready_o),
        .pot_nurn_i(pot_nurn_i), .pot_i(pot_i),
        .Addr_Config_B_o(Addr_Config_B_o), .rdEn_Config_B_o(rdEn_Config_B_o),
        .NurnType_i(NurnType_i), .RandTh_i(RandTh_i), .Th_Mask_i(Th_Mask_i),
        .RstPot_i(RstPot_i), .SpikeAER_i(SpikeAER_i),
        .wb_valid_o(wb_valid_o), .wb_nurn_o(wb_nurn_o), .wb_pot_o(wb_pot_o),
        .spike_valid_o(spike_valid_o), .spike_ready_i(spike_ready_i),
        .spike_aer_o(spike_aer_o), .fifo_cnt_o(fifo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Per-neuron configuration table
    logic        cfg_type [256];
    logic        cfg_rand [256];
    logic [15:0] cfg_mask [256];
    logic [15:0] cfg_rst  [256];
    logic [31:0] cfg_aer  [256];

    // Config memory port B: registered read, data valid the cycle after rdEn
    always @(posedge clk_i) begin
        if (rdEn_Config_B_o) begin
            NurnType_i <= cfg_type[Addr_Config_B_o];
            RandTh_i   <= cfg_rand[Addr_Config_B_o];
            Th_Mask_i  <= cfg_mask[Addr_Config_B_o];
            RstPot_i   <= cfg_rst[Addr_Config_B_o];
            SpikeAER_i <= cfg_aer[Addr_Config_B_o];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_s1_valid;
    logic [7:0]  m_s1_nurn;
    logic [15:0] m_s1_pot;
    logic        m_wb_valid;
    logic [7:0]  m_wb_nurn;
    logic [15:0] m_wb_pot;
    logic [15:0] m_lfsr;
    logic [31:0] spike_q [$];
    logic        last_acc;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return (v >> 1) ^ ((v % 2 == 1) ? 16'hB400 : 16'h0000);
    endfunction

    task automatic modelReset();
        m_s1_valid = 1'b0;
        m_s1_nurn  = '0;
        m_s1_pot   = '0;
        m_wb_valid = 1'b0;
        m_wb_nurn  = '0;
        m_wb_pot   = '0;
        m_lfsr     = 16'hACE1;
        spike_q.delete();
    endtask

    // Advance the model by one clock edge
    task automatic modelEdge(input logic acc, input logic [7:0] n, input logic [15:0] p, input logic pop);
        logic [15:0] th;
        logic        fire;
        int          idx;
        fire       = 1'b0;
        m_wb_valid = m_s1_valid;
        if (m_s1_valid) begin
            idx = int'(m_s1_nurn);
            if (cfg_rand[idx]) begin
                th     = m_lfsr & cfg_mask[idx];
                m_lfsr = lfsrNext(m_lfsr);
            end else begin
                th = cfg_mask[idx];
            end
            m_wb_nurn = m_s1_nurn;
            if (cfg_type[idx]) begin
                m_wb_pot = ($signed(m_s1_pot) < 0) ? 16'h0000 : m_s1_pot;
            end else begin
                fire     = ($signed(m_s1_pot) >= $signed(th));
                m_wb_pot = fire ? cfg_rst[idx] : m_s1_pot;
            end
        end
        if (pop) void'(spike_q.pop_front());
        if (fire) spike_q.push_back(cfg_aer[idx]);
        m_s1_valid = acc;
        if (acc) begin
            m_s1_nurn = n;
            m_s1_pot  = p;
        end
    endtask

    task automatic checkState();
        checkOutput("wb_valid", wb_valid_o, m_wb_valid);
        if (m_wb_valid) begin
            checkOutput("wb_nurn", wb_nurn_o, m_wb_nurn);
            checkOutput("wb_pot", wb_pot_o, m_wb_pot);
        end
        checkOutput("spike_valid", spike_valid_o, spike_q.size() != 0);
        if (spike_q.size() != 0) checkOutput("spike_aer", spike_aer_o, spike_q[0]);
        checkOutput("fifo_cnt", fifo_cnt_o, spike_q.size());
    endtask

    // One clock of stimulus; entered and left just after a falling edge
    task automatic applyStimulus(input logic v, input logic [7:0] n, input logic [15:0] p, input logic rdy);
        logic exp_ready;
        logic exp_pop;
        pot_valid_i   = v;
        pot_nurn_i    = n;
        pot_i         = p;
        spike_ready_i = rdy;
        #1;
        exp_ready = (spike_q.size() + int'(m_s1_valid)) < 8;
        checkOutput("pot_ready", pot_ready_o, exp_ready);
        last_acc = v & exp_ready;
        checkOutput("rd_en", rdEn_Config_B_o, last_acc);
        if (last_acc) checkOutput("rd_addr", Addr_Config_B_o, n);
        exp_pop = (spike_q.size() != 0) & rdy;
        @(posedge clk_i);
        modelEdge(last_acc, n, p, exp_pop);
        @(negedge clk_i);
        checkState();
    endtask

    task automatic checkResetValues();
        checkOutput("rst_pot_ready", pot_ready_o, 1'b1);
        checkOutput("rst_rd_en", rdEn_Config_B_o, 1'b0);
        checkOutput("rst_addr_follow", Addr_Config_B_o, pot_nurn_i);
        checkOutput("rst_wb_valid", wb_valid_o, 1'b0);
        checkOutput("rst_wb_nurn", wb_nurn_o, 8'h00);
        checkOutput("rst_wb_pot", wb_pot_o, 16'h0000);
        checkOutput("rst_spike_valid", spike_valid_o, 1'b0);
        checkOutput("rst_fifo_cnt", fifo_cnt_o, 4'h0);
    endtask

    task automatic setNeuron(input int n, input logic t, input logic r, input logic [15:0] m,
                             input logic [15:0] rp, input logic [31:0] aer);
        cfg_type[n] = t;
        cfg_rand[n] = r;
        cfg_mask[n] = m;
        cfg_rst[n]  = rp;
        cfg_aer[n]  = aer;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 8'h00, 16'h0000, 1'b1);
    endtask

    initial begin
        int accepted;
        rst_n_i       = 1'b0;
        pot_valid_i   = 1'b0;
        pot_nurn_i    = 8'h3C;
        pot_i         = '0;
        spike_ready_i = 1'b0;
        for (int i = 0; i < 256; i++) setNeuron(i, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 32'(i));
        modelReset();
        last_acc = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        checkResetValues();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        $display("[TB] reset released");

        // Random threshold from seed, then frozen across a fixed-threshold neuron
        setNeuron(9,  1'b0, 1'b1, 16'h00FF, 16'h0001, 32'h0009_0000);
        setNeuron(10, 1'b0, 1'b1, 16'h00FF, 16'h0002, 32'h000A_0000);
        setNeuron(11, 1'b0, 1'b1, 16'h00FF, 16'h0003, 32'h000B_0000);
        setNeuron(12, 1'b0, 1'b0, 16'h0010, 16'h0004, 32'h000C_0000);
        applyStimulus(1'b1, 8'd9, 16'h00E0, 1'b1);
        applyStimulus(1'b1, 8'd9, 16'h00E1, 1'b1);
        checkOutput("rand_below_seed_th", wb_pot_o, 16'h00E0);
        applyStimulus(1'b1, 8'd10, 16'h0070, 1'b1);
        checkOutput("rand_at_seed_th", wb_pot_o, 16'h0001);
        applyStimulus(1'b1, 8'd12, 16'h0020, 1'b1);
        applyStimulus(1'b1, 8'd11, 16'h0037, 1'b1);
        applyStimulus(1'b1, 8'd11, 16'h0038, 1'b1);
        idle(4);

        // Fixed I&F fire on neuron 5
        setNeuron(5, 1'b0, 1'b0, 16'h0080, 16'h0000, 32'h0005_0001);
        applyStimulus(1'b1, 8'd5, 16'h0100, 1'b1);
        applyStimulus(1'b0, 8'd0, 16'h0000, 1'b0);
        checkOutput("if_fire_wb_pot", wb_pot_o, 16'h0000);
        applyStimulus(1'b0, 8'd0, 16'h0000, 1'b0);
        checkOutput("if_fire_spike_aer", spike_aer_o, 32'h0005_0001);
        idle(3);

        // Below threshold and negative potentials pass through unchanged
        setNeuron(6, 1'b0, 1'b0, 16'h0080, 16'h1234, 32'h0006_0000);
        applyStimulus(1'b1, 8'd6, 16'h007F, 1'b1);
        applyStimulus(1'b1, 8'd6, 16'hFF00, 1'b1);
        checkOutput("below_th_wb", wb_pot_o, 16'h007F);
        applyStimulus(1'b0, 8'd0, 16'h0000, 1'b1);
        checkOutput("negative_wb", wb_pot_o, 16'hFF00);
        checkOutput("no_spike_below", fifo_cnt_o, 4'h0);

        // ReLU clamps negatives and never fires
        setNeuron(8, 1'b1, 1'b0, 16'h0000, 16'h5555, 32'h0008_0000);
        applyStimulus(1'b1, 8'd8, 16'hFFF0, 1'b1);
        applyStimulus(1'b1, 8'd8, 16'h0042, 1'b1);
        checkOutput("relu_neg_wb", wb_pot_o, 16'h0000);
        applyStimulus(1'b0, 8'd0, 16'h0000, 1'b1);
        checkOutput("relu_pos_wb", wb_pot_o, 16'h0042);
        checkOutput("relu_no_spike", fifo_cnt_o, 4'h0);
        idle(2);

        // Backpressure: 12 firing neurons against a stalled router
        for (int i = 0; i < 12; i++) setNeuron(30 + i, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h00AA_0000 | 32'(i));
        accepted = 0;
        for (int c = 0; c < 30 && accepted < 12; c++) begin
            applyStimulus(1'b1, 8'(30 + accepted), 16'h0010, 1'b0);
            if (last_acc) accepted++;
        end
        checkOutput("bp_accepted", 64'(accepted), 64'd8);
        checkOutput("bp_fifo_full", fifo_cnt_o, 4'd8);
        checkOutput("bp_ready_low", pot_ready_o, 1'b0);
        idle(12);
        checkOutput("bp_drained", fifo_cnt_o, 4'd0);

        // Async reset with one neuron in flight and three spikes queued
        for (int i = 0; i < 4; i++) setNeuron(20 + i, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h00BB_0000 | 32'(i));
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(20 + i), 16'h0001, 1'b0);
        checkOutput("pre_rst_fifo", fifo_cnt_o, 4'd3);
        pot_valid_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        checkResetValues();
        modelReset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        applyStimulus(1'b1, 8'd23, 16'h0005, 1'b1);
        applyStimulus(1'b0, 8'd0, 16'h0000, 1'b1);
        checkOutput("post_rst_wb_nurn", wb_nurn_o, 8'd23);
        idle(3);

        // Randomized traffic over randomized configurations
        for (int i = 0; i < 256; i++) begin
            setNeuron(i, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      16'($urandom_range(0, 16'h01FF)), 16'($urandom), $urandom);
        end
        for (int c = 0; c < 500; c++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 16'($urandom_range(0, 16'h03FF)) - 16'h0100,
                          1'($urandom_range(0, 2) != 0));
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
